// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial W-bit adder. A single 1-bit full-adder slice is
//               reused over W cycles, LSB first, between a valid/ready
//               operand interface and a valid/ready result interface.
//               Area is favoured over latency: one operation takes W+2
//               cycles minimum (accept, W shift cycles, result handshake).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W            operand/result width in bits (W >= 1)
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid_i   operand set a_i/b_i/cin_i is valid
//   in_ready_o   block idle and able to accept operands
//   a_i, b_i     W-bit operands
//   cin_i        carry into bit 0
//   out_valid_o  sum_o/cout_o hold a finished result
//   out_ready_i  consumer accepts the result
//   sum_o        registered (a+b+cin) modulo 2**W
//   cout_o       registered carry out of bit W-1
//   ovf_o        registered two's-complement overflow (only when
//                SERIAL_ADD_OVF_EN is defined)
// Build option
//   SERIAL_ADD_OVF_EN : adds the ovf_o port and its flop
// ============================================================================
module serial_adder_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    localparam int              CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       s_sh_q, s_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // The shared full-adder slice.
    logic fa_sum;
    logic fa_cout;
    assign fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // Sum shift register after inserting this cycle's bit at the MSB end.
    // After W insertions bit 0 of the result has reached position 0.
    logic [W-1:0] s_shift;
    generate
        if (W == 1) begin : g_w1
            assign s_shift = fa_sum;
        end else begin : g_wn
            assign s_shift = {fa_sum, s_sh_q[W-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    sum_d   = s_shift;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this last cycle.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end
            ST_DONE: begin
                // in_ready_o is low here, so a result handshake can never
                // coincide with an operand acceptance.
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule
`default_nettype wire
